// File: rtl/cache_mem_arbiter_pkg.sv
// Memory message formats shared by the caches, the arbiter and main memory.
package definitions;

    localparam int abw = 32;
    localparam int clw = 128;

    localparam logic [2:0] READ  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;

    typedef struct packed {
        logic [2:0]     msg_type;
        logic [7:0]     opaque;
        logic [abw-1:0] addr;
        logic [3:0]     len;
        logic [clw-1:0] data;
    } mem_req_t;

    typedef struct packed {
        logic [2:0]     msg_type;
        logic [7:0]     opaque;
        logic [1:0]     test;
        logic [3:0]     len;
        logic [clw-1:0] data;
    } mem_resp_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side val/rdy bundle around the memory arbiter.
interface cache_mem_arbiter_if #(parameter int NREQ = 2);
    import definitions::*;

    logic [NREQ-1:0] cachereq_val;
    logic [NREQ-1:0] cachereq_rdy;
    mem_req_t        cachereq_msg [NREQ];
    logic [NREQ-1:0] cacheresp_val;
    logic [NREQ-1:0] cacheresp_rdy;
    mem_resp_t       cacheresp_msg;

    logic            memreq_val;
    logic            memreq_rdy;
    mem_req_t        memreq_msg;
    logic            memresp_val;
    logic            memresp_rdy;
    mem_resp_t       memresp_msg;

    // The arbiter side.
    modport slave (
        input  cachereq_val, cachereq_msg, cacheresp_rdy,
               memreq_rdy, memresp_val, memresp_msg,
        output cachereq_rdy, cacheresp_val, cacheresp_msg,
               memreq_val, memreq_msg, memresp_rdy
    );

    // The caches plus memory surrounding the arbiter.
    modport master (
        output cachereq_val, cachereq_msg, cacheresp_rdy,
               memreq_rdy, memresp_val, memresp_msg,
        input  cachereq_rdy, cacheresp_val, cacheresp_msg,
               memreq_val, memreq_msg, memresp_rdy
    );

endinterface

// File: rtl/cache_mem_arbiter_id_fifo.sv
// In-order FIFO of requester indices, one entry per in-flight memory transaction.
module id_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  entries [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin sharing of one main-memory port among NREQ caches, with in-order response routing.
module cache_mem_arbiter
    import definitions::*;
#(
    parameter int NREQ  = 2,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    cache_mem_arbiter_if.slave  bus
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   head;
    logic            any_val;
    logic            full;
    logic            empty;
    logic            accept;
    logic            resp_xfer;
    logic [NREQ-1:0] req_rdy;
    logic [NREQ-1:0] resp_val;

    // Scan from the highest offset down so the first valid at or after rr_ptr wins.
    always_comb begin
        grant   = rr_ptr;
        cand    = '0;
        any_val = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_ptr) + k) % NREQ);
            if (bus.cachereq_val[cand]) begin
                grant   = cand;
                any_val = 1'b1;
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        if (any_val && bus.memreq_rdy && !full && !reset) req_rdy[grant] = 1'b1;
    end

    assign bus.cachereq_rdy = req_rdy;
    assign bus.memreq_val   = any_val && !full && !reset;
    assign bus.memreq_msg   = bus.cachereq_msg[grant];
    assign accept           = bus.memreq_val && bus.memreq_rdy;

    // Full blocks grants even when a pop lands in the same cycle, keeping resp->req paths apart.
    always_comb begin
        resp_val = '0;
        if (bus.memresp_val && !empty && !reset) resp_val[head] = 1'b1;
    end

    assign bus.cacheresp_val = resp_val;
    assign bus.cacheresp_msg = bus.memresp_msg;
    assign bus.memresp_rdy   = !empty && bus.cacheresp_rdy[head] && !reset;
    assign resp_xfer         = bus.memresp_val && bus.memresp_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    id_fifo #(
        .W     (IW),
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (grant),
        .pop       (resp_xfer),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized scoreboard bench for cache_mem_arbiter with a queue-based reference model.
module tb_cache_mem_arbiter;
    import definitions::*;

    localparam int NREQ  = 2;
    localparam int DEPTH = 4;
    localparam int IW    = $clog2(NREQ);

    typedef struct packed {
        logic [NREQ-1:0] req_rdy;
        logic            memreq_val;
        mem_req_t        memreq_msg;
        logic [NREQ-1:0] resp_val;
        logic            memresp_rdy;
        mem_resp_t       resp_msg;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.NREQ(NREQ)) bus ();

    cache_mem_arbiter #(
        .NREQ  (NREQ),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: priority index, routing order, memory's pending replies.
    int              rr;
    int              inflight [$];
    mem_resp_t       mem_pending [$];
    mem_req_t        cur_msg [$];
    logic [NREQ-1:0] hold_val;
    int              seq;
    exp_t            exp_q [$];
    exp_t            ex;
    int              tests;
    int              fails;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic mem_req_t new_msg(input int r);
        mem_req_t m;
        seq++;
        m.msg_type = ($urandom_range(1) == 1) ? WRITE : READ;
        m.opaque   = {r[1:0], seq[5:0]};
        m.addr     = $urandom;
        m.len      = 4'd0;
        m.data     = {$urandom, $urandom, $urandom, $urandom};
        return m;
    endfunction

    function automatic mem_resp_t mem_reply(input mem_req_t q);
        mem_resp_t p;
        p.msg_type = q.msg_type;
        p.opaque   = q.opaque;
        p.test     = 2'd0;
        p.len      = 4'd0;
        p.data     = {32'hDEADBEEF, q.addr, ~q.addr, 32'hCAFEF00D};
        return p;
    endfunction

    // One cycle: drive inputs, push the expected outputs, advance the model.
    task automatic step(input int p_val, input int p_mrdy, input int p_resp,
                        input int p_crdy, input bit do_rst);
        exp_t      e;
        mem_resp_t stray;
        int        g;
        int        h;
        int        idx;
        bit        full;
        @(posedge clk);
        #1;
        reset = do_rst;
        for (int r = 0; r < NREQ; r++) begin
            if (!hold_val[r[IW-1:0]] && $urandom_range(99) < p_val) hold_val[r[IW-1:0]] = 1'b1;
            bus.cachereq_msg[r[IW-1:0]] = cur_msg[r];
            bus.cacheresp_rdy[r[IW-1:0]] = ($urandom_range(99) < p_crdy);
        end
        bus.cachereq_val = hold_val;
        bus.memreq_rdy   = ($urandom_range(99) < p_mrdy);
        if (mem_pending.size() > 0 && $urandom_range(99) < p_resp) begin
            bus.memresp_val = 1'b1;
            bus.memresp_msg = mem_pending[0];
        end else begin
            stray.msg_type  = READ;
            stray.opaque    = 8'hFF;
            stray.test      = 2'd3;
            stray.len       = 4'd0;
            stray.data      = {$urandom, $urandom, $urandom, $urandom};
            bus.memresp_msg = stray;
            bus.memresp_val = (mem_pending.size() == 0) && ($urandom_range(99) < 8);
        end

        e = '0;
        g = -1;
        if (!do_rst) begin
            full = (inflight.size() == DEPTH);
            for (int k = 0; k < NREQ; k++) begin
                idx = (rr + k) % NREQ;
                if (g < 0 && hold_val[idx[IW-1:0]]) g = idx;
            end
            if (g >= 0 && !full) begin
                e.memreq_val = 1'b1;
                e.memreq_msg = cur_msg[g];
                if (bus.memreq_rdy) e.req_rdy[g[IW-1:0]] = 1'b1;
            end
            if (inflight.size() > 0) begin
                h = inflight[0];
                e.memresp_rdy = bus.cacheresp_rdy[h[IW-1:0]];
                if (bus.memresp_val) begin
                    e.resp_val[h[IW-1:0]] = 1'b1;
                    e.resp_msg = bus.memresp_msg;
                end
            end
        end
        exp_q.push_back(e);

        if (do_rst) begin
            rr = 0;
            inflight.delete();
            mem_pending.delete();
            hold_val = '0;
        end else begin
            if (bus.memresp_val && e.memresp_rdy) begin
                void'(inflight.pop_front());
                void'(mem_pending.pop_front());
            end
            if (g >= 0 && e.req_rdy[g[IW-1:0]]) begin
                inflight.push_back(g);
                mem_pending.push_back(mem_reply(cur_msg[g]));
                rr = (g + 1) % NREQ;
                hold_val[g[IW-1:0]] = 1'b0;
                cur_msg[g] = new_msg(g);
            end
        end
    endtask

    // Monitor: compare every DUT output against the expectation queued for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            chk("cachereq_rdy", 256'(bus.cachereq_rdy), 256'(ex.req_rdy));
            chk("memreq_val", 256'(bus.memreq_val), 256'(ex.memreq_val));
            chk("cacheresp_val", 256'(bus.cacheresp_val), 256'(ex.resp_val));
            chk("memresp_rdy", 256'(bus.memresp_rdy), 256'(ex.memresp_rdy));
            if (ex.memreq_val) chk("memreq_msg", 256'(bus.memreq_msg), 256'(ex.memreq_msg));
            if (ex.resp_val != '0) chk("cacheresp_msg", 256'(bus.cacheresp_msg), 256'(ex.resp_msg));
        end
    end

    initial begin
        tests    = 0;
        fails    = 0;
        rr       = 0;
        seq      = 0;
        hold_val = '0;
        reset    = 1'b1;
        for (int r = 0; r < NREQ; r++) cur_msg.push_back(new_msg(r));
        bus.cachereq_val  = '0;
        bus.cacheresp_rdy = '0;
        bus.memreq_rdy    = 1'b0;
        bus.memresp_val   = 1'b0;
        bus.memresp_msg   = '0;
        for (int r = 0; r < NREQ; r++) bus.cachereq_msg[r[IW-1:0]] = '0;

        // Reset with requests pending: every val/rdy output stays low.
        step(100, 100, 100, 100, 1'b1);
        step(100, 100, 100, 100, 1'b1);

        // Light single-requester traffic, then sustained contention.
        for (int i = 0; i < 20; i++) step(30, 100, 100, 100, 1'b0);
        for (int i = 0; i < 30; i++) step(100, 100, 100, 100, 1'b0);

        // Fill the routing FIFO with no replies, then drain one at a time.
        for (int i = 0; i < 10; i++) step(100, 100, 0, 100, 1'b0);
        for (int i = 0; i < 12; i++) step(100, 100, 50, 100, 1'b0);

        // Several outstanding, then reset mid-flight, then contention again.
        for (int i = 0; i < 3; i++) step(100, 100, 0, 100, 1'b0);
        step(100, 100, 100, 100, 1'b1);
        for (int i = 0; i < 8; i++) step(100, 100, 100, 100, 1'b0);

        // Response backpressure from the caches.
        for (int i = 0; i < 200; i++) step(60, 80, 70, 30, 1'b0);

        // Mixed random phases with occasional resets.
        for (int p = 0; p < 24; p++) begin
            int pv, pm, pr, pc;
            pv = $urandom_range(100, 10);
            pm = $urandom_range(100, 20);
            pr = $urandom_range(100, 0);
            pc = $urandom_range(100, 20);
            for (int i = 0; i < 40; i++) step(pv, pm, pr, pc, ($urandom_range(99) < 2));
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drain", 256'(exp_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares one cacheline-wide main-memory port among `NREQ` cache memory ports (default: icache and dcache) in the lab3 memory subsystem. Each cache's refill/evict requests pass through a round-robin arbiter. A small in-order routing FIFO records the winning requester of every accepted request, and each memory response is steered back to that requester. The block adds no latency on either path; its state is the priority pointer and the routing FIFO.

## Interface
Parameters:
- `NREQ`, 2, number of requesting cache ports (2–4).
- `DEPTH`, 4, routing-FIFO entries, i.e. maximum in-flight memory transactions (power of two).

Ports (clock and reset first; the only clock is `clk`; `reset` is synchronous and active-high):
- `clk` in 1, system clock.
- `reset` in 1, synchronous, active-high.
- `cachereq_val` in `NREQ`, per-requester request valid.
- `cachereq_rdy` out `NREQ`, per-requester request ready.
- `cachereq_msg` in `NREQ` x `mem_req_t`, per-requester request message.
- `cacheresp_val` out `NREQ`, per-requester response valid.
- `cacheresp_rdy` in `NREQ`, per-requester response ready.
- `cacheresp_msg` out `mem_resp_t`, broadcast to all requesters; only the valid one consumes it.
- `memreq_val` out 1 / `memreq_rdy` in 1 / `memreq_msg` out `mem_req_t`, downstream request.
- `memresp_val` in 1 / `memresp_rdy` out 1 / `memresp_msg` in `mem_resp_t`, downstream response.

## Operation
- Transfers use val/rdy handshakes. A transfer happens in a cycle where val && rdy.
- Grant is combinational. Starting at `rr_ptr`, pick the first index i with `cachereq_val[i]`. Search wraps modulo `NREQ`.
- `memreq_val` = any `cachereq_val` && !fifo_full.
- `memreq_msg` = msg of the grantee, passed unmodified; the opaque field is not rewritten.
- `cachereq_rdy[i]` = (i == grant) && memreq_rdy && !fifo_full. All other bits are 0.
- On an accepted request:
  - push the grantee index into the FIFO;
  - set `rr_ptr` to (grant+1) mod `NREQ`.
- With no accepted request, `rr_ptr` holds.
- Response path: head = FIFO head index.
  - `cacheresp_val[head]` = memresp_val && !fifo_empty. All other bits are 0.
  - `memresp_rdy` = !fifo_empty && `cacheresp_rdy[head]`.
  - On a transfer, pop the FIFO.
- Memory returns responses in request order. The FIFO relies on this.
- Boundary rules:
  - FIFO full: no new grant, even if a pop happens in the same cycle. This keeps the resp->req combinational path out.
  - FIFO empty: `memresp_rdy`=0, so a stray response is never accepted. The bench flags it.
  - Simultaneous push and pop when not full: both take effect, and the count is unchanged.
  - Pointer and count wrap modulo `DEPTH` and `NREQ`.
- Reset, including mid-transaction:
  - `rr_ptr`=0; FIFO empty (rd/wr pointers 0, count 0).
  - All val/rdy outputs are 0 in the cycle after reset is asserted and while it is held.
  - In-flight entries are discarded.
  - Memory and caches are reset together, so no orphan responses arrive.

## Timing
- Request path: zero cycles. A cache request appears on `memreq` in the same cycle.
- Response path: zero cycles.
- Grant is stable only while the chosen requester holds val. A higher-priority val arriving changes the grant before acceptance, which is legal under val/rdy.
- FIFO count reflects a push in the cycle after the accepting edge.
- Throughput: one request and one response per cycle.
- Fairness: under sustained contention, each requester is granted at most once per `NREQ` accepted requests.

## Structure
- Shared package `definitions` (extended) holds:
  - `mem_req_t`: type 3, opaque 8, addr `abw`, len 4, data `clw`;
  - `mem_resp_t`: type 3, opaque 8, test 2, len 4, data `clw`;
  - the message-type constants (READ=0, WRITE=1).
- `rr_ptr` is local to this block.
- One sub-module: `id_fifo`, parameterised by width $clog2(`NREQ`) and `DEPTH`. It provides push/pop/full/empty/head and a synchronous active-high reset.

## Test plan
- Single requester: req0 READ addr 0x100, mem rdy=1.
  - `memreq` carries it in the same cycle.
  - Response data 0xDEADBEEF_... returns on `cacheresp_val[0]` only.
- Contention: both requesters hold val for 6 cycles with mem rdy=1.
  - Grants alternate 0,1,0,1,0,1.
  - Responses route in the same order.
- Full FIFO (`DEPTH`=4): 4 accepted requests with no responses.
  - The 5th request sees rdy=0.
  - After one response pops, the 5th is accepted on the following cycle, not the same cycle.
- Backpressure: requester 1 response rdy=0 while the head is id1.
  - `memresp_rdy`=0; the response is held and not dropped.
  - Requester 0's later response stays blocked behind it.
- Reset mid-flight: 2 outstanding, then reset asserted for 1 cycle.
  - All outputs are 0 and the FIFO is empty.
  - The next request from requester 1 is granted after requester 0's, since `rr_ptr`=0.
- Stray response with empty FIFO: `memresp_rdy` stays 0 and no `cacheresp_val` is asserted.
